// File: rtl/diff_amp_cal_ctrl.sv
// Offset-calibration sequencer: shorts the amp inputs, runs a SAR search over the trim code
// using a synchronized comparator, then releases the short and holds the result.
module diff_amp_cal_ctrl #(
  parameter int unsigned TRIM_W   = 6,
  parameter int unsigned SETTLE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic                cmp_in,
  output logic                cal_short,
  output logic [TRIM_W-1:0]   trim_code,
  output logic                busy,
  output logic                done,
  output logic                cal_fail
);

  localparam int unsigned IDX_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam logic [TRIM_W-1:0] MIDSCALE = {1'b1, {(TRIM_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(TRIM_W - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_TRIAL  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [SETTLE_W-1:0] reload_q, reload_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TRIM_W-1:0]   trim_q, trim_d;
  logic [TRIM_W-1:0]   backup_q, backup_d;
  logic                busy_q, busy_d;
  logic                short_q, short_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic                cmp_meta_q, cmp_s_q;
  logic [SETTLE_W-1:0] reload_in;

  // Per-step counter reload is S-1 with S = max(settle_cycles, 1).
  assign reload_in = (settle_cycles == '0) ? '0 : settle_cycles - SETTLE_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    idx_d    = idx_q;
    trim_d   = trim_q;
    backup_d = backup_q;
    busy_d   = busy_q;
    short_d  = short_q;
    done_d   = done_q;
    fail_d   = fail_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          backup_d = trim_q;
          trim_d   = MIDSCALE;
          done_d   = 1'b0;
          fail_d   = 1'b0;
          busy_d   = 1'b1;
          short_d  = 1'b1;
          reload_d = reload_in;
          cnt_d    = reload_in;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE, ST_TRIAL: begin
        if (abort) begin
          trim_d  = backup_q;
          busy_d  = 1'b0;
          short_d = 1'b0;
          done_d  = 1'b0;
          fail_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - SETTLE_W'(1);
        end else if (state_q == ST_SETTLE) begin
          cnt_d   = reload_q;
          idx_d   = IDX_TOP;
          state_d = ST_TRIAL;
        end else begin
          // Comparator high means the trial code overshoots: drop the bit under test.
          if (cmp_s_q) trim_d[idx_q] = 1'b0;
          if (idx_q != '0) begin
            idx_d                      = idx_q - IDX_W'(1);
            trim_d[idx_q - IDX_W'(1)]  = 1'b1;
            cnt_d                      = reload_q;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        short_d = 1'b0;
        done_d  = 1'b1;
        fail_d  = (trim_q == '0) || (trim_q == '1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      reload_q   <= '0;
      idx_q      <= IDX_TOP;
      trim_q     <= MIDSCALE;
      backup_q   <= MIDSCALE;
      busy_q     <= 1'b0;
      short_q    <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      cmp_meta_q <= 1'b0;
      cmp_s_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      reload_q   <= reload_d;
      idx_q      <= idx_d;
      trim_q     <= trim_d;
      backup_q   <= backup_d;
      busy_q     <= busy_d;
      short_q    <= short_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      cmp_meta_q <= cmp_in;
      cmp_s_q    <= cmp_meta_q;
    end
  end

  assign cal_short = short_q;
  assign trim_code = trim_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cal_fail  = fail_q;

endmodule
